// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory interface.
// Turns RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word
// accesses on a memory with a one-cycle registered read port. Loads are
// lane-selected and extended; sub-word stores use read-modify-write.
module load_store_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WIDTH-1:0]  resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    DATA,
    RESP
  } state_t;

  state_t state, state_next;

  logic              lat_we;
  logic [2:0]        lat_f3;
  logic [ADDR_W+1:0] lat_addr;
  logic [WIDTH-1:0]  lat_wdata;
  logic [WIDTH-1:0]  rdata_q;
  logic              err_q;

  logic              accept;
  logic              req_err;
  logic [WIDTH-1:0]  shifted;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [WIDTH-1:0]  load_ext;
  logic [WIDTH-1:0]  store_merge;

  assign accept     = req_valid && req_ready;
  assign mem_addr   = lat_addr[ADDR_W+1:2];
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Classify the incoming request: illegal funct3 or misaligned half/word.
  always_comb begin
    req_err = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'b000:  req_err = 1'b0;
        3'b001:  req_err = req_addr[0];
        3'b010:  req_err = |req_addr[1:0];
        default: req_err = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b100: req_err = 1'b0;
        3'b001, 3'b101: req_err = req_addr[0];
        3'b010:         req_err = |req_addr[1:0];
        default:        req_err = 1'b1;
      endcase
    end
  end

  // Pick the addressed lane out of the read word and extend it for loads.
  always_comb begin
    shifted   = mem_rdata >> {lat_addr[1:0], 3'b000};
    lane_byte = shifted[7:0];
    lane_half = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_f3)
      3'b000:  load_ext = {{(WIDTH-8){lane_byte[7]}}, lane_byte};
      3'b100:  load_ext = {{(WIDTH-8){1'b0}}, lane_byte};
      3'b001:  load_ext = {{(WIDTH-16){lane_half[15]}}, lane_half};
      3'b101:  load_ext = {{(WIDTH-16){1'b0}}, lane_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Merge the store byte/half into the word just read back from memory.
  always_comb begin
    store_merge = mem_rdata;
    if (lat_f3 == 3'b000) begin
      store_merge[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
    end else begin
      store_merge[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
    end
  end

  // Next-state and handshake/memory strobes, all decoded from the current state.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wdata  = lat_wdata;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err) begin
            state_next = RESP;
          end else if (req_we && (req_funct3 == 3'b010)) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD: begin
        mem_read   = 1'b1;
        state_next = DATA;
      end
      DATA: begin
        mem_write  = lat_we;
        mem_wdata  = store_merge;
        state_next = RESP;
      end
      WR: begin
        mem_write  = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset drops any in-flight memory strobe immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latch the accepted request and build/hold the response until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_f3    <= 3'b000;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_f3    <= req_funct3;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        rdata_q   <= '0;
        err_q     <= req_err;
      end else if ((state == DATA) && !lat_we) begin
        rdata_q <= load_ext;
      end else if ((state == RESP) && resp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural data memory
// (registered read, write on posedge) and a queue-based scoreboard.
module tb_load_store_unit;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W+1:0] req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WIDTH-1:0]  resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  lat;
  } exp_t;

  exp_t exp_q[$];
  int   compares   = 0;
  int   mismatches = 0;

  load_store_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural DataMemory: write on posedge, read data registered one cycle.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compares++;
    if (got !== exp) begin
      mismatches++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                               input logic [9:0] addr, input logic [31:0] wdata,
                               input logic err, input logic [31:0] rdata, input int lat,
                               input int nrd, input int nwr, input logic [31:0] wval,
                               input int hold);
    exp_t e;
    int   cyc;
    int   rd_seen;
    int   wr_seen;
    bit   got;
    @(negedge clk);
    checkOutput({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wdata = '0;
    e.err   = err;
    e.rdata = rdata;
    e.lat   = 8'(lat);
    exp_q.push_back(e);
    cyc = 0; rd_seen = 0; wr_seen = 0; got = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      checkOutput({tag, " rd_wr_excl"}, {31'b0, mem_read & mem_write}, 32'd0);
      if (mem_read) rd_seen++;
      if (mem_write) begin
        wr_seen++;
        checkOutput({tag, " mem_wdata"}, mem_wdata, wval);
        checkOutput({tag, " mem_addr"}, {24'b0, mem_addr}, {24'b0, addr[9:2]});
      end
      if (resp_valid) got = 1;
    end
    if (!got) begin
      checkOutput({tag, " timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    checkOutput({tag, " latency"}, cyc, {24'b0, e.lat});
    checkOutput({tag, " resp_err"}, {31'b0, resp_err}, {31'b0, e.err});
    checkOutput({tag, " resp_rdata"}, resp_rdata, e.rdata);
    checkOutput({tag, " reads"}, rd_seen, nrd);
    checkOutput({tag, " writes"}, wr_seen, nwr);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, " hold valid"}, {31'b0, resp_valid}, 32'd1);
      checkOutput({tag, " hold ready"}, {31'b0, req_ready}, 32'd0);
      checkOutput({tag, " hold rdata"}, resp_rdata, e.rdata);
      checkOutput({tag, " hold err"}, {31'b0, resp_err}, {31'b0, e.err});
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checkOutput({tag, " after"}, {30'b0, resp_valid, resp_err}, 32'd0);
  endtask

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
    mem_rdata  = '0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst resp_err", {31'b0, resp_err}, 32'd0);
    checkOutput("rst mem_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    rst = 1'b0;

    // Reset asserted while a load is in its read cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 10'h010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    checkOutput("mid mem_read", {31'b0, mem_read}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("mid resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("mid mem_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // tag, we, f3, addr, wdata, err, rdata, lat, reads, writes, wval, hold
    applyStimulus("SW",      1'b1, 3'b010, 10'h010, 32'hDEADBEEF, 1'b0, 32'h0,        2, 0, 1, 32'hDEADBEEF, 0);
    checkOutput("mem[4] SW", mem[4], 32'hDEADBEEF);
    applyStimulus("LB 13",   1'b0, 3'b000, 10'h013, 32'h0,        1'b0, 32'hFFFFFFDE, 3, 1, 0, 32'h0, 0);
    applyStimulus("LBU 13",  1'b0, 3'b100, 10'h013, 32'h0,        1'b0, 32'h000000DE, 3, 1, 0, 32'h0, 0);
    applyStimulus("LH 12",   1'b0, 3'b001, 10'h012, 32'h0,        1'b0, 32'hFFFFDEAD, 3, 1, 0, 32'h0, 0);
    applyStimulus("LHU 12",  1'b0, 3'b101, 10'h012, 32'h0,        1'b0, 32'h0000DEAD, 3, 1, 0, 32'h0, 0);
    applyStimulus("LW 10",   1'b0, 3'b010, 10'h010, 32'h0,        1'b0, 32'hDEADBEEF, 3, 1, 0, 32'h0, 0);
    applyStimulus("LB 10",   1'b0, 3'b000, 10'h010, 32'h0,        1'b0, 32'hFFFFFFEF, 3, 1, 0, 32'h0, 0);
    applyStimulus("SB 11",   1'b1, 3'b000, 10'h011, 32'h00000055, 1'b0, 32'h0,        3, 1, 1, 32'hDEAD55EF, 0);
    applyStimulus("SH 12",   1'b1, 3'b001, 10'h012, 32'h00001234, 1'b0, 32'h0,        3, 1, 1, 32'h123455EF, 0);
    applyStimulus("LW 10b",  1'b0, 3'b010, 10'h010, 32'h0,        1'b0, 32'h123455EF, 3, 1, 0, 32'h0, 0);
    applyStimulus("LH 10",   1'b0, 3'b001, 10'h010, 32'h0,        1'b0, 32'h000055EF, 3, 1, 0, 32'h0, 0);
    applyStimulus("SW FC",   1'b1, 3'b010, 10'h0FC, 32'hCAFEF00D, 1'b0, 32'h0,        2, 0, 1, 32'hCAFEF00D, 0);
    applyStimulus("LB FE",   1'b0, 3'b000, 10'h0FE, 32'h0,        1'b0, 32'hFFFFFFFE, 3, 1, 0, 32'h0, 0);

    // Error cases: no memory traffic, one-cycle latency.
    applyStimulus("err LW 12", 1'b0, 3'b010, 10'h012, 32'h0,      1'b1, 32'h0, 1, 0, 0, 32'h0, 0);
    applyStimulus("err LH 13", 1'b0, 3'b001, 10'h013, 32'h0,      1'b1, 32'h0, 1, 0, 0, 32'h0, 0);
    applyStimulus("err ld 011",1'b0, 3'b011, 10'h010, 32'h0,      1'b1, 32'h0, 1, 0, 0, 32'h0, 0);
    applyStimulus("err SW 11", 1'b1, 3'b010, 10'h011, 32'h1111,   1'b1, 32'h0, 1, 0, 0, 32'h0, 0);
    applyStimulus("err st 011",1'b1, 3'b011, 10'h010, 32'h2222,   1'b1, 32'h0, 1, 0, 0, 32'h0, 0);

    // Response back-pressure on a load.
    applyStimulus("hold LBU",1'b0, 3'b100, 10'h011, 32'h0,        1'b0, 32'h00000055, 3, 1, 0, 32'h0, 3);

    // Reset during the write cycle of an SB: memory must stay untouched.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 10'h010; req_wdata = 32'h000000AA;
    @(posedge clk);
    #1 req_valid = 1'b0; req_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstSB mem_write", {31'b0, mem_write}, 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstSB drop", {31'b0, mem_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstSB mem[4]", mem[4], 32'h123455EF);
    applyStimulus("LW after",1'b0, 3'b010, 10'h010, 32'h0,        1'b0, 32'h123455EF, 3, 1, 0, 32'h0, 0);

    checkOutput("queue empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
